beat_trigger_ctrl: RTL and testbench

- Downstream consumer of the accelerometer beat detector's beat_en / beat_intensity outputs.
- Converts each new beat into one 4-phase request/acknowledge transaction to the sample-playback block, carrying the 2-bit intensity.
- Enforces a refractory holdoff so one physical hit yields one sound.
- Counts accepted beats, flags beats dropped while busy, and recovers from a missing acknowledge by timeout.

---
 rtl/beat_trigger_ctrl.sv | 109 ++++++++++
 tb/tb_beat_trigger_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_trigger_ctrl.sv
// Turns each new beat into one 4-phase req/ack transaction to playback, followed by a refractory holdoff.
// Outputs registered (req one cycle after the sampled edge); beats arriving while busy are dropped and flagged.
module beat_trigger_ctrl #(
  parameter int HOLDOFF_CYCLES = 2500000,
  parameter int ACK_TIMEOUT    = 1000000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_en,
  input  logic [1:0]       beat_intensity,
  input  logic             play_ack,
  output logic             play_req,
  output logic [1:0]       play_level,
  output logic [CNT_W-1:0] beat_count,
  output logic             busy,
  output logic             dropped,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, REL, HOLDOFF} state_t;

  localparam logic [23:0] TO_LAST = 24'(ACK_TIMEOUT - 1);
  localparam logic [23:0] HO_LAST = 24'(HOLDOFF_CYCLES - 1);

  state_t      state;
  logic [23:0] timer;
  logic        en_q;
  logic        evt;

  assign evt = beat_en & ~en_q & (beat_intensity != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      en_q        <= 1'b0;
      play_req    <= 1'b0;
      play_level  <= 2'd0;
      beat_count  <= '0;
      busy        <= 1'b0;
      dropped     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      en_q        <= beat_en;
      timeout_err <= 1'b0;
      // Any edge seen outside IDLE is rejected, including the HOLDOFF->IDLE cycle.
      dropped     <= evt && (state != IDLE);

      case (state)
        IDLE: begin
          if (evt) begin
            state      <= REQ;
            busy       <= 1'b1;
            play_req   <= 1'b1;
            play_level <= beat_intensity;
            beat_count <= beat_count + CNT_W'(1);
            timer      <= '0;
          end
        end

        REQ: begin
          if (play_ack) begin
            play_req <= 1'b0;
            state    <= REL;
            timer    <= '0;
          end else if (timer == TO_LAST) begin
            play_req    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= HOLDOFF;
            timer       <= HO_LAST;
          end else begin
            timer <= timer + 24'd1;
          end
        end

        REL: begin
          if (!play_ack) begin
            state <= HOLDOFF;
            timer <= HO_LAST;
          end else if (timer == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= HOLDOFF;
            timer       <= HO_LAST;
          end else begin
            timer <= timer + 24'd1;
          end
        end

        HOLDOFF: begin
          if (timer == 24'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 24'd1;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          play_req <= 1'b0;
          timer    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beat_trigger_ctrl.sv
// Bench for beat_trigger_ctrl: directed scenarios plus random traffic against a phase/elapsed-cycle model.
module tb_beat_trigger_ctrl;

  localparam int HOLD = 8;
  localparam int TOUT = 16;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          beat_en = 1'b0;
  logic [1:0]    beat_intensity = 2'd0;
  logic          play_ack = 1'b0;
  logic          play_req;
  logic [1:0]    play_level;
  logic [CW-1:0] beat_count;
  logic          busy;
  logic          dropped;
  logic          timeout_err;

  beat_trigger_ctrl #(.HOLDOFF_CYCLES(HOLD), .ACK_TIMEOUT(TOUT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .beat_en(beat_en), .beat_intensity(beat_intensity),
    .play_ack(play_ack), .play_req(play_req), .play_level(play_level),
    .beat_count(beat_count), .busy(busy), .dropped(dropped), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 request, 2 release, 3 holdoff; m_cnt = cycles elapsed in phase.
  int m_ph, m_cnt, m_count, m_level;
  bit m_prev, m_req, m_busy, m_drop, m_to;
  bit auto_ack = 1'b0;
  int n_busy, n_req, n_drop, n_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_count = 0; m_level = 0;
    m_prev = 0; m_req = 0; m_busy = 0; m_drop = 0; m_to = 0;
  endtask

  task automatic model_step();
    bit evt;
    int old;
    if (!rst) begin
      model_reset();
      return;
    end
    evt  = beat_en && !m_prev && (beat_intensity != 0);
    old  = m_ph;
    m_to = 0;
    case (m_ph)
      0: if (evt) begin
        m_ph = 1; m_cnt = 0; m_req = 1;
        m_level = int'(beat_intensity);
        m_count = (m_count + 1) % (1 << CW);
      end
      1: begin
        m_cnt++;
        if (play_ack) begin m_req = 0; m_ph = 2; m_cnt = 0; end
        else if (m_cnt == TOUT) begin m_req = 0; m_to = 1; m_ph = 3; m_cnt = 0; end
      end
      2: begin
        m_cnt++;
        if (!play_ack) begin m_ph = 3; m_cnt = 0; end
        else if (m_cnt == TOUT) begin m_to = 1; m_ph = 3; m_cnt = 0; end
      end
      default: begin
        m_cnt++;
        if (m_cnt == HOLD) begin m_ph = 0; m_cnt = 0; end
      end
    endcase
    m_drop = (old != 0) && evt;
    m_prev = beat_en;
    m_busy = (m_ph != 0);
  endtask

  task automatic check_all();
    check("play_req", play_req, m_req);
    check("play_level", play_level, m_level);
    check("beat_count", beat_count, m_count);
    check("busy", busy, m_busy);
    check("dropped", dropped, m_drop);
    check("timeout_err", timeout_err, m_to);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    n_busy += int'(busy);
    n_req  += int'(play_req);
    n_drop += int'(dropped);
    n_to   += int'(timeout_err);
    if (auto_ack) play_ack = play_req;
  endtask

  task automatic clear_counts();
    n_busy = 0; n_req = 0; n_drop = 0; n_to = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; beat_en = 1'b0; play_ack = 1'b0; auto_ack = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    rst = 1'b1;
    clear_counts();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 80) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    model_reset();
    clear_counts();

    // 1: single beat, ack after 3 REQ cycles, ack held 2 more cycles
    do_reset();
    beat_intensity = 2'd2; beat_en = 1'b1;
    tick();
    check("t1_req_rise", play_req, 1);
    check("t1_level", play_level, 2);
    beat_en = 1'b0;
    repeat (3) tick();
    play_ack = 1'b1;
    tick();
    check("t1_req_fall", play_req, 0);
    repeat (2) tick();
    play_ack = 1'b0;
    repeat (20) tick();
    check("t1_busy_cycles", n_busy, 15);
    check("t1_req_cycles", n_req, 4);
    check("t1_count", beat_count, 1);

    // 2: level held high for 40 cycles
    do_reset();
    auto_ack = 1'b1; beat_intensity = 2'd3; beat_en = 1'b1;
    repeat (40) tick();
    beat_en = 1'b0;
    repeat (20) tick();
    check("t2_count", beat_count, 1);
    check("t2_drops", n_drop, 0);
    check("t2_req_cycles", n_req, 1);

    // 3: edge 3 cycles into holdoff is dropped; later edge accepted
    do_reset();
    auto_ack = 1'b1; beat_intensity = 2'd1; beat_en = 1'b1;
    tick();
    beat_en = 1'b0;
    for (int i = 0; i < 40 && m_ph != 3; i++) tick();
    check("t3_reach_holdoff", m_ph, 3);
    repeat (2) tick();
    beat_en = 1'b1;
    tick();
    check("t3_drop_pulse", dropped, 1);
    check("t3_count_kept", beat_count, 1);
    beat_en = 1'b0;
    tick();
    check("t3_drop_one_cycle", dropped, 0);
    wait_idle("t3_idle_timeout");
    tick();
    beat_en = 1'b1; beat_intensity = 2'd2;
    tick();
    check("t3_accept_count", beat_count, 2);
    check("t3_accept_level", play_level, 2);
    beat_en = 1'b0;
    // edge on the very cycle holdoff expires is still dropped
    for (int i = 0; i < 40 && !(m_ph == 3 && m_cnt == HOLD - 1); i++) tick();
    beat_en = 1'b1;
    tick();
    check("t3_edge_at_exit_drop", dropped, 1);
    check("t3_edge_at_exit_busy", busy, 0);
    check("t3_edge_at_exit_count", beat_count, 2);
    beat_en = 1'b0;
    repeat (3) tick();

    // 4a: no acknowledge at all
    do_reset();
    beat_intensity = 2'd2; beat_en = 1'b1;
    tick();
    beat_en = 1'b0;
    repeat (40) tick();
    check("t4a_req_cycles", n_req, TOUT);
    check("t4a_timeouts", n_to, 1);
    check("t4a_busy_cycles", n_busy, TOUT + HOLD);

    // 4b: acknowledge stuck high, timeout in release phase
    do_reset();
    play_ack = 1'b1; beat_intensity = 2'd1; beat_en = 1'b1;
    tick();
    beat_en = 1'b0;
    repeat (40) tick();
    check("t4b_req_cycles", n_req, 1);
    check("t4b_timeouts", n_to, 1);
    check("t4b_busy_cycles", n_busy, 1 + TOUT + HOLD);
    play_ack = 1'b0;

    // 5: zero intensity ignored, then counter wrap
    do_reset();
    beat_intensity = 2'd0; beat_en = 1'b1;
    repeat (10) tick();
    check("t5_zero_req", n_req, 0);
    check("t5_zero_busy", n_busy, 0);
    beat_en = 1'b0;
    auto_ack = 1'b1; beat_intensity = 2'd1;
    for (int k = 0; k < 16; k++) begin
      tick();
      beat_en = 1'b1;
      tick();
      beat_en = 1'b0;
      wait_idle("t5_idle_timeout");
      if (k == 14) check("t5_count_15", beat_count, 15);
    end
    check("t5_count_wrap", beat_count, 0);

    // 6: reset mid-request
    do_reset();
    beat_intensity = 2'd1; beat_en = 1'b1;
    tick();
    tick();
    check("t6_req_before", play_req, 1);
    rst = 1'b0;
    #1;
    model_reset();
    check("t6_async_req", play_req, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_count", beat_count, 0);
    tick();
    beat_en = 1'b0;
    rst = 1'b1;
    tick();
    beat_en = 1'b1; beat_intensity = 2'd3;
    tick();
    check("t6_fresh_req", play_req, 1);
    check("t6_fresh_level", play_level, 3);
    check("t6_fresh_count", beat_count, 1);

    // random traffic against the model
    do_reset();
    for (int seg = 0; seg < 10; seg++) begin
      auto_ack = ($urandom_range(0, 1) == 1);
      if (!auto_ack && $urandom_range(0, 2) == 0) play_ack = 1'b0;
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 3) == 0) beat_en = ~beat_en;
        beat_intensity = 2'($urandom_range(0, 3));
        if (!auto_ack && $urandom_range(0, 4) == 0) play_ack = ~play_ack;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
